// File: rtl/stereo_gain_arbiter_pkg.sv
// Shared types and default scaling constants for the stereo gain arbiter.
// Imported by the arbiter top and its gain_scale datapath.
package stereo_gain_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_MUL   = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    typedef enum logic {
        CH_L = 1'b0,
        CH_R = 1'b1
    } ch_e;

    localparam int DEF_FRAC_BITS = 10;
    localparam int DEF_OUT_SHIFT = 4;

endpackage

// File: rtl/stereo_gain_arbiter_gain_scale.sv
// Combinational dequantize (round toward zero), left shift and
// truncation of the full-width gain product back to sample width.
module gain_scale
    import stereo_gain_arbiter_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int OUT_SHIFT = DEF_OUT_SHIFT
) (
    input  logic signed [2*DATA_SIZE-1:0] prod_i,
    output logic signed [DATA_SIZE-1:0]   result_o
);

    logic signed [2*DATA_SIZE-1:0] mag;
    logic signed [2*DATA_SIZE-1:0] deq;
    logic signed [2*DATA_SIZE-1:0] shl;

    assign mag = -prod_i;

    // Shift the magnitude so negative products truncate toward zero.
    always_comb begin
        deq = prod_i >>> FRAC_BITS;
        if (prod_i[2*DATA_SIZE-1]) begin
            deq = -(mag >>> FRAC_BITS);
        end
    end

    assign shl      = deq <<< OUT_SHIFT;
    assign result_o = shl[DATA_SIZE-1:0];

endmodule

// File: rtl/stereo_gain_arbiter.sv
// Two-channel volume scaler: arbitrates left/right FIFOs onto one shared
// multiplier, three cycles per sample, volume changes applied only between samples.
module stereo_gain_arbiter
    import stereo_gain_arbiter_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int OUT_SHIFT = DEF_OUT_SHIFT
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic signed [DATA_SIZE-1:0] vol_in,
    input  logic                        vol_wr_en,
    input  logic signed [DATA_SIZE-1:0] in_l,
    input  logic signed [DATA_SIZE-1:0] in_r,
    input  logic                        in_l_empty,
    input  logic                        in_r_empty,
    output logic                        in_l_rd_en,
    output logic                        in_r_rd_en,
    output logic signed [DATA_SIZE-1:0] out_l,
    output logic signed [DATA_SIZE-1:0] out_r,
    input  logic                        out_l_full,
    input  logic                        out_r_full,
    output logic                        out_l_wr_en,
    output logic                        out_r_wr_en,
    output logic                        busy
);

    localparam int PW = 2 * DATA_SIZE;

    state_e                  state_q, state_d;
    ch_e                     prio_q, prio_d;
    ch_e                     ch_q, ch_d;
    logic signed [DATA_SIZE-1:0] sample_q, sample_d;
    logic signed [PW-1:0]    prod_q, prod_d;
    logic signed [DATA_SIZE-1:0] act_vol_q, act_vol_d;
    logic signed [DATA_SIZE-1:0] pend_vol_q, pend_vol_d;
    logic                    vol_pend_q, vol_pend_d;

    logic                    elig_l, elig_r, grant_r;
    logic                    rd_l, rd_r, wr_l, wr_r;
    logic signed [DATA_SIZE-1:0] data_l, data_r;
    logic signed [DATA_SIZE-1:0] result;
    logic signed [PW-1:0]    sample_x, vol_x;

    assign elig_l   = !in_l_empty && !out_l_full;
    assign elig_r   = !in_r_empty && !out_r_full;
    assign sample_x = {{DATA_SIZE{sample_q[DATA_SIZE-1]}}, sample_q};
    assign vol_x    = {{DATA_SIZE{act_vol_q[DATA_SIZE-1]}}, act_vol_q};

    gain_scale #(
        .DATA_SIZE (DATA_SIZE),
        .FRAC_BITS (FRAC_BITS),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_gain_scale (
        .prod_i   (prod_q),
        .result_o (result)
    );

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        ch_d       = ch_q;
        sample_d   = sample_q;
        prod_d     = prod_q;
        act_vol_d  = act_vol_q;
        pend_vol_d = pend_vol_q;
        vol_pend_d = vol_pend_q;
        grant_r    = 1'b0;
        rd_l       = 1'b0;
        rd_r       = 1'b0;
        wr_l       = 1'b0;
        wr_r       = 1'b0;
        data_l     = '0;
        data_r     = '0;

        unique case (state_q)
            ST_ARB: begin
                if (elig_l || elig_r) begin
                    grant_r  = elig_r && (!elig_l || prio_q == CH_R);
                    ch_d     = grant_r ? CH_R : CH_L;
                    sample_d = grant_r ? in_r : in_l;
                    rd_l     = !grant_r;
                    rd_r     = grant_r;
                    state_d  = ST_MUL;
                end
            end
            ST_MUL: begin
                prod_d  = sample_x * vol_x;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (ch_q == CH_L && !out_l_full) begin
                    wr_l   = 1'b1;
                    data_l = result;
                end
                if (ch_q == CH_R && !out_r_full) begin
                    wr_r   = 1'b1;
                    data_r = result;
                end
                if (wr_l || wr_r) begin
                    prio_d  = (prio_q == CH_L) ? CH_R : CH_L;
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase

        // A same-cycle write re-arms pending after the apply above it.
        if (state_q == ST_ARB && vol_pend_q) begin
            act_vol_d  = pend_vol_q;
            vol_pend_d = 1'b0;
        end
        if (vol_wr_en) begin
            pend_vol_d = vol_in;
            vol_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_ARB;
            prio_q     <= CH_L;
            ch_q       <= CH_L;
            sample_q   <= '0;
            prod_q     <= '0;
            act_vol_q  <= '0;
            pend_vol_q <= '0;
            vol_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            ch_q       <= ch_d;
            sample_q   <= sample_d;
            prod_q     <= prod_d;
            act_vol_q  <= act_vol_d;
            pend_vol_q <= pend_vol_d;
            vol_pend_q <= vol_pend_d;
        end
    end

    assign in_l_rd_en  = reset_n && rd_l;
    assign in_r_rd_en  = reset_n && rd_r;
    assign out_l_wr_en = reset_n && wr_l;
    assign out_r_wr_en = reset_n && wr_r;
    assign out_l       = reset_n ? data_l : '0;
    assign out_r       = reset_n ? data_r : '0;
    assign busy        = reset_n && (state_q != ST_ARB);

endmodule

// File: tb/tb_stereo_gain_arbiter.sv
// Bench for stereo_gain_arbiter: FIFO queues plus a transaction-level
// reference model predicting every strobe and output each cycle.
module tb_stereo_gain_arbiter;

    localparam int W    = 32;
    localparam int FRAC = 10;
    localparam int OSH  = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic signed [W-1:0] vol_in = '0;
    logic vol_wr_en = 1'b0;
    logic signed [W-1:0] in_l = '0, in_r = '0;
    logic in_l_empty = 1'b1, in_r_empty = 1'b1;
    logic in_l_rd_en, in_r_rd_en;
    logic signed [W-1:0] out_l, out_r;
    logic out_l_full = 1'b0, out_r_full = 1'b0;
    logic out_l_wr_en, out_r_wr_en;
    logic busy;

    always #5 clock = ~clock;

    stereo_gain_arbiter #(.DATA_SIZE(W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .vol_in      (vol_in),
        .vol_wr_en   (vol_wr_en),
        .in_l        (in_l),
        .in_r        (in_r),
        .in_l_empty  (in_l_empty),
        .in_r_empty  (in_r_empty),
        .in_l_rd_en  (in_l_rd_en),
        .in_r_rd_en  (in_r_rd_en),
        .out_l       (out_l),
        .out_r       (out_r),
        .out_l_full  (out_l_full),
        .out_r_full  (out_r_full),
        .out_l_wr_en (out_l_wr_en),
        .out_r_wr_en (out_r_wr_en),
        .busy        (busy)
    );

    int errors = 0;
    int checks = 0;

    int ql[$];
    int qr[$];
    bit full_l = 0, full_r = 0;

    // reference model state
    bit m_inflight = 0;
    bit m_ch = 0;
    bit m_prio = 0;
    int m_val = 0;
    int m_vol = 0;
    int m_ready = 0;
    int cyc = 0;

    int wo_ch[$];
    int wo_val[$];

    typedef struct {
        bit ch;
        int vol;
        int sample;
        int exp;
    } vec_t;
    vec_t tv[9];

    function automatic int scale(input int s, input int v);
        longint p, q;
        p = longint'(s) * longint'(v);
        q = p / (longint'(1) << FRAC);
        return int'(q * (longint'(1) << OSH));
    endfunction

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic step(input bit do_vol = 0, input int vol = 0);
        bit el_l, el_r, g_l, g_r, w_l, w_r;
        int s;
        el_l = 0; el_r = 0; g_l = 0; g_r = 0; w_l = 0; w_r = 0;
        @(negedge clock);
        in_l_empty = (ql.size() == 0);
        in_r_empty = (qr.size() == 0);
        in_l = 0;
        in_r = 0;
        if (ql.size() != 0) in_l = ql[0];
        if (qr.size() != 0) in_r = qr[0];
        out_l_full = full_l;
        out_r_full = full_r;
        vol_wr_en = do_vol;
        vol_in = vol;
        #1;
        if (!m_inflight) begin
            el_l = !in_l_empty && !full_l;
            el_r = !in_r_empty && !full_r;
            if (el_l && el_r) begin
                g_l = (m_prio == 0);
                g_r = !g_l;
            end else begin
                g_l = el_l;
                g_r = el_r;
            end
        end else if (cyc >= m_ready) begin
            w_l = (m_ch == 0) && !full_l;
            w_r = (m_ch == 1) && !full_r;
        end
        check("strobes{busy,rdl,rdr,wrl,wrr}",
              {busy, in_l_rd_en, in_r_rd_en, out_l_wr_en, out_r_wr_en},
              {m_inflight, g_l, g_r, w_l, w_r});
        check("out_l", out_l, w_l ? m_val : 0);
        check("out_r", out_r, w_r ? m_val : 0);
        if (out_l_wr_en) begin wo_ch.push_back(0); wo_val.push_back(out_l); end
        if (out_r_wr_en) begin wo_ch.push_back(1); wo_val.push_back(out_r); end
        if (g_l || g_r) begin
            s = g_l ? ql.pop_front() : qr.pop_front();
            m_val = scale(s, m_vol);
            m_ch = g_r;
            m_inflight = 1;
            m_ready = cyc + 2;
        end
        if (w_l || w_r) begin
            m_inflight = 0;
            m_prio = !m_prio;
        end
        if (do_vol) m_vol = vol;
        cyc++;
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        full_l = 0;
        full_r = 0;
        while ((ql.size() != 0 || qr.size() != 0 || m_inflight) && n < maxc) begin
            step();
            n++;
        end
        check("drain{ql,qr,inflight}",
              {ql.size() != 0, qr.size() != 0, m_inflight}, 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        in_l_empty = 1'b1;
        in_r_empty = 1'b1;
        vol_wr_en = 1'b0;
        #1;
        check("reset_strobes",
              {busy, in_l_rd_en, in_r_rd_en, out_l_wr_en, out_r_wr_en}, 0);
        check("reset_out_l", out_l, 0);
        check("reset_out_r", out_r, 0);
        m_inflight = 0;
        m_prio = 0;
        m_vol = 0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        tv[0] = '{0, 1024, 100, 1600};
        tv[1] = '{1, 512, -3, -16};
        tv[2] = '{0, 1024, -100, -1600};
        tv[3] = '{0, 1, 1023, 0};
        tv[4] = '{1, 1, -1023, 0};
        tv[5] = '{0, 2048, 32'h1000_0000, 0};
        tv[6] = '{1, 1024, 32'h0800_0000, int'(32'h8000_0000)};
        tv[7] = '{0, -1024, 5, -80};
        tv[8] = '{1, 1536, -7, -160};

        repeat (3) @(negedge clock);
        #1;
        check("por_strobes",
              {busy, in_l_rd_en, in_r_rd_en, out_l_wr_en, out_r_wr_en}, 0);
        check("por_out", {out_l, out_r}, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // interleave with left priority out of reset
        step(1, 1024);
        ql.push_back(11); ql.push_back(12);
        qr.push_back(21); qr.push_back(22);
        wo_ch.delete(); wo_val.delete();
        drain(30);
        check("order_cnt", wo_val.size(), 4);
        if (wo_val.size() == 4) begin
            check("order0", {wo_ch[0], wo_val[0]}, {32'd0, 32'd176});
            check("order1", {wo_ch[1], wo_val[1]}, {32'd1, 32'd336});
            check("order2", {wo_ch[2], wo_val[2]}, {32'd0, 32'd192});
            check("order3", {wo_ch[3], wo_val[3]}, {32'd1, 32'd352});
        end

        for (int i = 0; i < 9; i++) begin
            step(1, tv[i].vol);
            if (tv[i].ch) qr.push_back(tv[i].sample);
            else ql.push_back(tv[i].sample);
            n0 = wo_val.size();
            drain(10);
            check($sformatf("vec%0d_cnt", i), wo_val.size() - n0, 1);
            if (wo_val.size() == n0 + 1) begin
                check($sformatf("vec%0d_ch", i), wo_ch[n0], tv[i].ch);
                check($sformatf("vec%0d_val", i), wo_val[n0], tv[i].exp);
            end
        end

        // output full stall for 5 cycles in WRITE
        step(1, 1024);
        ql.push_back(100);
        step();
        step();
        full_l = 1;
        n0 = wo_val.size();
        repeat (5) step();
        check("stall_no_write", wo_val.size() - n0, 0);
        full_l = 0;
        step();
        step();
        check("stall_one_write", wo_val.size() - n0, 1);
        if (wo_val.size() == n0 + 1) check("stall_val", wo_val[n0], 1600);

        // volume write during MUL affects only the next sample
        step(1, 1024);
        ql.push_back(100);
        step();
        step(1, 2048);
        n0 = wo_val.size();
        step();
        check("volmul_old_cnt", wo_val.size() - n0, 1);
        if (wo_val.size() == n0 + 1) check("volmul_old", wo_val[n0], 1600);
        ql.push_back(100);
        n0 = wo_val.size();
        drain(10);
        check("volmul_new_cnt", wo_val.size() - n0, 1);
        if (wo_val.size() == n0 + 1) check("volmul_new", wo_val[n0], 3200);

        // reset while in MUL with priority on right
        if (m_prio == 0) begin
            qr.push_back(1);
            drain(10);
        end
        ql.push_back(9);
        step();
        n0 = wo_val.size();
        do_reset();
        step(1, 1024);
        check("rst_no_write", wo_val.size() - n0, 0);
        ql.push_back(3);
        qr.push_back(4);
        step();
        check("rst_grant_left", {in_l_rd_en, in_r_rd_en}, 2'b10);
        drain(20);
        check("rst_cnt", wo_val.size() - n0, 2);
        if (wo_val.size() == n0 + 2) begin
            check("rst_w0", {wo_ch[n0], wo_val[n0]}, {32'd0, 32'd48});
            check("rst_w1", {wo_ch[n0+1], wo_val[n0+1]}, {32'd1, 32'd64});
        end

        // randomized traffic against the model
        for (int i = 0; i < 900; i++) begin
            bit dv;
            int v;
            if ($urandom_range(0, 2) == 0 && ql.size() < 8) ql.push_back(int'($urandom));
            if ($urandom_range(0, 2) == 0 && qr.size() < 8) qr.push_back(int'($urandom));
            full_l = ($urandom_range(0, 3) == 0);
            full_r = ($urandom_range(0, 3) == 0);
            dv = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 1) == 0) v = int'($urandom_range(0, 8192)) - 4096;
            else v = int'($urandom);
            step(dv, v);
        end
        drain(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
